// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizes for the writeback arbiter and the issue logic that
// depends on the number of FUs and CDB lanes.
package cdb_arbiter_pkg;

    localparam int NUM_FU     = 4;
    localparam int NUM_CDB    = 2;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [4:0] rob_id;
        logic [5:0] pd;
    } inst_info_t;

    typedef struct packed {
        logic                ready_for_writeback;
        inst_info_t          inst_info;
        logic [31:0]         register_value;
    } fu_output_t;

    // What a per-FU FIFO actually stores: the valid bit is implied by occupancy.
    typedef struct packed {
        inst_info_t          inst_info;
        logic [31:0]         register_value;
    } wb_payload_t;

    typedef struct packed {
        logic                valid;
        inst_info_t          inst_info;
        logic [31:0]         register_value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result / stall / flush / CDB bundle between the functional units and the writeback arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU  = cdb_arbiter_pkg::NUM_FU,
    parameter int NUM_CDB = cdb_arbiter_pkg::NUM_CDB
);
    import cdb_arbiter_pkg::*;

    fu_output_t [NUM_FU-1:0]  fu_result;
    logic       [NUM_FU-1:0]  fu_stall;
    logic                     flush;
    cdb_entry_t [NUM_CDB-1:0] cdb;

    modport master (output fu_result, output flush, input fu_stall, input cdb);
    modport slave  (input fu_result, input flush, output fu_stall, output cdb);

endinterface

// File: rtl/cdb_arbiter_fu_wb_fifo.sv
// Per-FU result FIFO: push at the edge, head visible combinationally, flush empties it.
module cdb_arbiter_fu_wb_fifo #(
    parameter int DEPTH = cdb_arbiter_pkg::FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  cdb_arbiter_pkg::wb_payload_t push_data_i,
    output cdb_arbiter_pkg::wb_payload_t head_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    import cdb_arbiter_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_payload_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && !full;

    // NOTE: every _d signal takes its hold value first, so no path through this block infers a latch.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the payload array has no reset; a slot is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && full));

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: buffers each FU's results and round-robins up to NUM_CDB of them per
// cycle onto the common data bus, stalling FUs early enough that nothing is ever dropped.
module cdb_arbiter #(
    parameter int NUM_FU     = cdb_arbiter_pkg::NUM_FU,
    parameter int NUM_CDB    = cdb_arbiter_pkg::NUM_CDB,
    parameter int FIFO_DEPTH = cdb_arbiter_pkg::FIFO_DEPTH
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);
    import cdb_arbiter_pkg::*;

    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_payload_t              head  [NUM_FU];
    logic [CNT_W-1:0]         count [NUM_FU];
    logic [NUM_FU-1:0]        grant;
    logic [NUM_FU-1:0]        stall;
    logic [RR_W-1:0]          rr_q, rr_d;
    cdb_entry_t [NUM_CDB-1:0] lanes;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        wb_payload_t push_data;
        assign push_data = '{inst_info:      bus.fu_result[g].inst_info,
                             register_value: bus.fu_result[g].register_value};

        cdb_arbiter_fu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (bus.fu_result[g].ready_for_writeback),
            .pop_i       (grant[g]),
            .flush_i     (bus.flush),
            .push_data_i (push_data),
            .head_o      (head[g]),
            .count_o     (count[g])
        );
    end

    // Rotating priority: pass 0 covers FUs at or above rr_q, pass 1 wraps to those below it.
    always_comb begin
        int n_granted;
        int last;
        grant     = '0;
        lanes     = '0;
        n_granted = 0;
        last      = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (((pass == 0) == (f >= int'(rr_q))) && (count[f] != '0) && (n_granted < NUM_CDB)) begin
                    grant[f] = 1'b1;
                    for (int l = 0; l < NUM_CDB; l++) begin
                        if (l == n_granted) begin
                            lanes[l] = '{valid:          1'b1,
                                         inst_info:      head[f].inst_info,
                                         register_value: head[f].register_value};
                        end
                    end
                    n_granted++;
                    last = f;
                end
            end
        end
        rr_d = rr_q;
        if ((n_granted != 0) && !bus.flush) begin
            rr_d = (last == NUM_FU - 1) ? '0 : RR_W'(last + 1);
        end
    end

    // One slot stays free for the result already in flight when the stall is first seen.
    always_comb begin
        stall = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            stall[f] = (count[f] >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end

    assign bus.cdb      = lanes;
    assign bus.fu_stall = stall;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-FU queues plus a modulo round-robin scan serve as reference.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    wb_payload_t              mq [NUM_FU][$];
    int                       rr;
    cdb_entry_t [NUM_CDB-1:0] exp_cdb;
    logic [NUM_FU-1:0]        exp_stall;
    logic [NUM_FU-1:0]        exp_grant;
    int                       exp_last;
    logic [NUM_FU-1:0]        pending;
    int                       seq;

    function automatic void model_eval();
        int n = 0;
        exp_cdb   = '0;
        exp_grant = '0;
        exp_last  = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            int idx = (rr + k) % NUM_FU;
            if (mq[idx].size() > 0 && n < NUM_CDB) begin
                exp_cdb[n] = '{valid: 1'b1, inst_info: mq[idx][0].inst_info,
                               register_value: mq[idx][0].register_value};
                exp_grant[idx] = 1'b1;
                exp_last = idx;
                n++;
            end
        end
        for (int i = 0; i < NUM_FU; i++) exp_stall[i] = (mq[i].size() >= FIFO_DEPTH - 1);
    endfunction

    function automatic void model_step(input fu_output_t [NUM_FU-1:0] fin, input logic fl);
        int pre_size [NUM_FU];
        model_eval();
        if (fl) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            return;
        end
        for (int i = 0; i < NUM_FU; i++) pre_size[i] = mq[i].size();
        for (int i = 0; i < NUM_FU; i++) if (exp_grant[i]) void'(mq[i].pop_front());
        if (exp_last >= 0) rr = (exp_last + 1) % NUM_FU;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fin[i].ready_for_writeback && pre_size[i] < FIFO_DEPTH)
                mq[i].push_back('{inst_info: fin[i].inst_info, register_value: fin[i].register_value});
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        rr      = 0;
        pending = '0;
        model_eval();
    endfunction

    task automatic set_fu(input int i, input logic v, input logic [31:0] val);
        fu_output_t r;
        r.ready_for_writeback = v;
        r.inst_info.rob_id    = 5'(seq);
        r.inst_info.pd        = 6'(i);
        r.register_value      = val;
        bus.fu_result[i]      = r;
        seq++;
    endtask

    task automatic clear_inputs();
        bus.fu_result = '0;
        bus.flush     = 1'b0;
    endtask

    // Advance one clock: model consumes the inputs driven this cycle, outputs settle by negedge.
    task automatic tick();
        fu_output_t [NUM_FU-1:0] fin;
        logic fl;
        @(posedge clk);
        fin = bus.fu_result;
        fl  = bus.flush;
        model_step(fin, fl);
        @(negedge clk);
        model_eval();
    endtask

    // FU pipeline: an op issues only while its stall is low and its result appears a cycle later.
    task automatic issue_cycle(input logic [NUM_FU-1:0] want);
        for (int i = 0; i < NUM_FU; i++) set_fu(i, pending[i], $urandom);
        for (int i = 0; i < NUM_FU; i++) pending[i] = want[i] && !exp_stall[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_eval();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.cdb !== '0) begin
            errors++; $display("FAIL reset_cdb got %h exp 0", bus.cdb);
        end
        checks++;
        if (bus.fu_stall !== '0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", bus.fu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_fu(0, 1'b1, 32'h11);
        set_fu(1, 1'b1, 32'h22);
        set_fu(2, 1'b1, 32'h33);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb !== exp_cdb) begin
            errors++; $display("FAIL reset_pre_cdb got %h exp %h", bus.cdb, exp_cdb);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < NUM_CDB; l++) begin
            checks++;
            if (bus.cdb[l].valid !== 1'b0) begin
                errors++; $display("FAIL reset_async_valid lane%0d got %b exp 0", l, bus.cdb[l].valid);
            end
        end
        checks++;
        if (bus.fu_stall !== '0) begin
            errors++; $display("FAIL reset_async_stall got %b exp 0", bus.fu_stall);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.cdb !== exp_cdb) begin
            errors++; $display("FAIL reset_release_cdb got %h exp %h", bus.cdb, exp_cdb);
        end
    endtask

    task automatic test_single();
        set_fu(2, 1'b1, 32'h0000_00AA);
        checks++;
        if (bus.cdb[0].valid !== 1'b0) begin
            errors++; $display("FAIL single_same_cycle valid got %b exp 0", bus.cdb[0].valid);
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb[0].valid !== 1'b1 || bus.cdb[0].register_value !== 32'h0000_00AA) begin
            errors++; $display("FAIL single_lane0 got v=%b val=%h exp v=1 val=000000aa",
                               bus.cdb[0].valid, bus.cdb[0].register_value);
        end
        checks++;
        if (bus.cdb[1] !== '0) begin
            errors++; $display("FAIL single_lane1 got %h exp 0", bus.cdb[1]);
        end
        tick();
        checks++;
        if (bus.cdb !== exp_cdb) begin
            errors++; $display("FAIL single_drain got %h exp %h", bus.cdb, exp_cdb);
        end
    endtask

    task automatic test_contention();
        int exp_pd [3][2] = '{'{0, 1}, '{2, 3}, '{0, 1}};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, {4'(i), 28'(c)});
            tick();
            checks++;
            if (bus.cdb[0].inst_info.pd !== 6'(exp_pd[c][0]) || bus.cdb[1].inst_info.pd !== 6'(exp_pd[c][1])) begin
                errors++; $display("FAIL contention_grant cyc%0d got {%0d,%0d} exp {%0d,%0d}", c,
                                   bus.cdb[0].inst_info.pd, bus.cdb[1].inst_info.pd, exp_pd[c][0], exp_pd[c][1]);
            end
            checks++;
            if (bus.cdb !== exp_cdb) begin
                errors++; $display("FAIL contention_cdb cyc%0d got %h exp %h", c, bus.cdb, exp_cdb);
            end
        end
        clear_inputs();
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (bus.cdb !== exp_cdb || bus.fu_stall !== exp_stall) begin
                errors++; $display("FAIL contention_drain cyc%0d got %h/%b exp %h/%b", c,
                                   bus.cdb, bus.fu_stall, exp_cdb, exp_stall);
            end
        end
    endtask

    task automatic test_wrap();
        for (int v = 1; v <= 10; v++) begin
            set_fu(3, 1'b1, 32'(v));
            tick();
            checks++;
            if (bus.cdb[0].valid !== 1'b1 || bus.cdb[0].register_value !== 32'(v) || bus.cdb[1].valid !== 1'b0) begin
                errors++; $display("FAIL wrap value got v=%b val=%0d lane1=%b exp v=1 val=%0d lane1=0",
                                   bus.cdb[0].valid, bus.cdb[0].register_value, bus.cdb[1].valid, v);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (bus.cdb !== exp_cdb) begin
            errors++; $display("FAIL wrap_drain got %h exp %h", bus.cdb, exp_cdb);
        end
    endtask

    task automatic test_stall();
        bit saw_stall1 = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            issue_cycle('1);
            tick();
            if (bus.fu_stall[1] === 1'b1) saw_stall1 = 1;
            checks++;
            if (bus.cdb !== exp_cdb || bus.fu_stall !== exp_stall) begin
                errors++; $display("FAIL stall_cycle cyc%0d got %h/%b exp %h/%b", c,
                                   bus.cdb, bus.fu_stall, exp_cdb, exp_stall);
            end
        end
        checks++;
        if (!saw_stall1) begin
            errors++; $display("FAIL stall_fu1_raised got 0 exp 1");
        end
        for (int c = 0; c < 12; c++) begin
            issue_cycle('0);
            tick();
            checks++;
            if (bus.cdb !== exp_cdb || bus.fu_stall !== exp_stall) begin
                errors++; $display("FAIL stall_drain cyc%0d got %h/%b exp %h/%b", c,
                                   bus.cdb, bus.fu_stall, exp_cdb, exp_stall);
            end
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, $urandom);
            tick();
        end
        clear_inputs();
        set_fu(0, 1'b1, 32'hF0F0_F0F0);
        bus.flush = 1'b1;
        checks++;
        if (bus.cdb !== exp_cdb || exp_cdb[0].valid !== 1'b1) begin
            errors++; $display("FAIL flush_pre_heads got %h exp %h", bus.cdb, exp_cdb);
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb !== '0) begin
            errors++; $display("FAIL flush_cdb got %h exp 0", bus.cdb);
        end
        checks++;
        if (bus.fu_stall !== '0) begin
            errors++; $display("FAIL flush_stall got %b exp 0", bus.fu_stall);
        end
        tick();
        checks++;
        if (bus.cdb !== '0) begin
            errors++; $display("FAIL flush_discard got %h exp 0", bus.cdb);
        end
        // rr_ptr was 0 before the flush; an untouched pointer grants FU0 first.
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, $urandom);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb !== exp_cdb || bus.cdb[0].inst_info.pd !== 6'd0) begin
            errors++; $display("FAIL flush_rr_kept got %h exp %h", bus.cdb, exp_cdb);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = $urandom;
            bus.flush = ($urandom_range(0, 24) == 0);
            issue_cycle(r[NUM_FU-1:0]);
            tick();
            checks++;
            if (bus.cdb !== exp_cdb || bus.fu_stall !== exp_stall) begin
                errors++; $display("FAIL random cyc%0d got %h/%b exp %h/%b", c,
                                   bus.cdb, bus.fu_stall, exp_cdb, exp_stall);
            end
        end
        bus.flush = 1'b0;
        for (int c = 0; c < 12; c++) begin
            issue_cycle('0);
            tick();
            checks++;
            if (bus.cdb !== exp_cdb || bus.fu_stall !== exp_stall) begin
                errors++; $display("FAIL random_drain cyc%0d got %h/%b exp %h/%b", c,
                                   bus.cdb, bus.fu_stall, exp_cdb, exp_stall);
            end
        end
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        seq    = 0;
        rst_n  = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_stall();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
